// File: rtl/bcd_conv_arbiter_if.sv
// Bus bundle for bcd_conv_arbiter.
//   master : requesters side (drives req/bin_data, observes results)
//   slave  : converter side
// Signals: req[REQ_N], bin_data[16*REQ_N], ack[REQ_N], bcd_out[20],
//          bcd_valid, grant_id[2], busy.
interface bcd_conv_arbiter_if #(parameter int REQ_N = 3);
  logic [REQ_N-1:0]    req;
  logic [16*REQ_N-1:0] bin_data;
  logic [REQ_N-1:0]    ack;
  logic [19:0]         bcd_out;
  logic                bcd_valid;
  logic [1:0]          grant_id;
  logic                busy;

  modport master (output req, bin_data,
                  input  ack, bcd_out, bcd_valid, grant_id, busy);
  modport slave  (input  req, bin_data,
                  output ack, bcd_out, bcd_valid, grant_id, busy);
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Shared 16-bit binary -> 5-digit BCD converter with round-robin arbitration
// among REQ_N (2..4) requesters. Double-dabble, one bit per cycle:
// IDLE (capture) -> 16 x SHIFT -> DONE (bcd_valid + ack pulse) -> IDLE.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : bcd_conv_arbiter_if.slave (req, bin_data, ack, bcd_out,
//            bcd_valid, grant_id, busy)
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN -- leading zero digits of
// the result are shown as 4'hF (units digit never blanked, 16'hFFFF
// sentinel unaffected).
module bcd_conv_arbiter #(
  parameter int REQ_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_conv_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] op;
  logic [19:0] sh, adj, sh_nxt;
  logic        sentinel;
  logic [1:0]  ptr, gid, win;
  logic        any;
  logic [15:0] sel_op;
  logic [19:0] bcd_q;

  // (p + i) mod REQ_N, p < REQ_N and i < REQ_N
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= REQ_N) s = s - REQ_N;
    return s[1:0];
  endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
  function automatic logic [19:0] fmt(input logic [19:0] v);
    logic [19:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int d = 4; d >= 1; d--) begin
      if (lead && (v[4*d +: 4] == 4'd0)) r[4*d +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction
`else
  function automatic logic [19:0] fmt(input logic [19:0] v);
    return v;
  endfunction
`endif

  // Round-robin pick: walk offsets high to low so the smallest offset
  // from ptr (highest priority) is the last writer.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = REQ_N-1; i >= 0; i--) begin
      if (bus.req[rr_idx(ptr, i)]) begin
        win = rr_idx(ptr, i);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    for (int k = 0; k < REQ_N; k++)
      if (win == 2'(k)) sel_op = bus.bin_data[16*k +: 16];
  end

  // Add-3 correction per digit, then shift in next operand bit.
  for (genvar d = 0; d < 5; d++) begin : g_dig
    assign adj[4*d +: 4] = (sh[4*d +: 4] > 4'd4) ? sh[4*d +: 4] + 4'd3
                                                 : sh[4*d +: 4];
  end
  assign sh_nxt = {adj[18:0], op[15]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.bcd_valid = (state == DONE);
    bus.ack       = '0;
    for (int k = 0; k < REQ_N; k++)
      bus.ack[k] = (state == DONE) && (gid == 2'(k));
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.grant_id = gid;

  // Datapath; capture happens only on IDLE->SHIFT so later req/operand
  // changes cannot disturb a running conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op       <= '0;
      sh       <= '0;
      cnt      <= '0;
      sentinel <= 1'b0;
      gid      <= '0;
      ptr      <= '0;
      bcd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          op       <= sel_op;
          sentinel <= (sel_op == 16'hFFFF);
          gid      <= win;
          ptr      <= rr_idx(win, 1);
          sh       <= '0;
          cnt      <= '0;
        end
        SHIFT: begin
          op  <= {op[14:0], 1'b0};
          sh  <= sh_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15)
            bcd_q <= sentinel ? 20'hFFFFF : fmt(sh_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_conv_arbiter_if #(.REQ_N(3)) bif ();

  bcd_conv_arbiter #(.REQ_N(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [19:0] E1234 = 20'hF1234, E0 = 20'hFFFF0, E42 = 20'hFFF42,
    E9999 = 20'hF9999, E907 = 20'hFF907, E100 = 20'hFF100, E200 = 20'hFF200,
    E300 = 20'hFF300, E4321 = 20'hF4321;
`else
  localparam logic [19:0] E1234 = 20'h01234, E0 = 20'h00000, E42 = 20'h00042,
    E9999 = 20'h09999, E907 = 20'h00907, E100 = 20'h00100, E200 = 20'h00200,
    E300 = 20'h00300, E4321 = 20'h04321;
`endif

  task automatic test_reset;
    rst_n = 1'b0;
    bif.req = '0;
    bif.bin_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bif.busy !== 1'b0 || bif.bcd_valid !== 1'b0 || bif.ack !== 3'b000 ||
        bif.bcd_out !== 20'h0 || bif.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b ack=%b bcd=%h gid=%0d, want all 0",
               bif.busy, bif.bcd_valid, bif.ack, bif.bcd_out, bif.grant_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle;
    bif.req = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bif.busy !== 1'b0 || bif.ack !== 3'b000 || bif.bcd_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle: busy=%b ack=%b valid=%b, want 0 0 0",
                 bif.busy, bif.ack, bif.bcd_valid);
      end
    end
  endtask

  task automatic test_basic;
    bif.bin_data[15:0] = 16'd1234;
    bif.req = 3'b001;
    @(negedge clk);
    checks++;
    if (bif.busy !== 1'b1 || bif.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL basic_capture: busy=%b gid=%0d, want 1 0", bif.busy, bif.grant_id);
    end
    bif.bin_data[15:0] = 16'd9;  // must not disturb the running conversion
    repeat (15) @(negedge clk);
    checks++;
    if (bif.bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: valid=%b at cycle 16, want 0", bif.bcd_valid);
    end
    bif.req = '0;
    @(negedge clk);
    checks++;
    if (bif.bcd_valid !== 1'b1 || bif.ack !== 3'b001 || bif.bcd_out !== E1234) begin
      errors++;
      $display("FAIL basic_done: valid=%b ack=%b bcd=%h, want 1 001 %h",
               bif.bcd_valid, bif.ack, bif.bcd_out, E1234);
    end
    @(negedge clk);
    checks++;
    if (bif.bcd_valid !== 1'b0 || bif.ack !== 3'b000 || bif.bcd_out !== E1234 ||
        bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: valid=%b ack=%b bcd=%h busy=%b, want 0 000 %h 0",
               bif.bcd_valid, bif.ack, bif.bcd_out, bif.busy, E1234);
    end
  endtask

  task automatic test_values;
    logic [15:0] vals [5];
    logic [19:0] exps [5];
    vals[0] = 16'd65535; exps[0] = 20'hFFFFF;
    vals[1] = 16'd65534; exps[1] = 20'h65534;
    vals[2] = 16'd0;     exps[2] = E0;
    vals[3] = 16'd42;    exps[3] = E42;
    vals[4] = 16'd9999;  exps[4] = E9999;
    for (int j = 0; j < 5; j++) begin
      bif.bin_data[15:0] = vals[j];
      bif.req = 3'b001;
      @(negedge clk);
      repeat (15) @(negedge clk);
      bif.req = '0;
      @(negedge clk);
      checks++;
      if (bif.bcd_valid !== 1'b1 || bif.ack !== 3'b001 || bif.bcd_out !== exps[j]) begin
        errors++;
        $display("FAIL value_%0d: valid=%b ack=%b bcd=%h, want 1 001 %h",
                 vals[j], bif.bcd_valid, bif.ack, bif.bcd_out, exps[j]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0]  g_exp [4];
    logic [19:0] b_exp [4];
    logic [2:0]  a_exp;
    g_exp[0] = 2'd0; g_exp[1] = 2'd1; g_exp[2] = 2'd2; g_exp[3] = 2'd0;
    b_exp[0] = E100; b_exp[1] = E200; b_exp[2] = E300; b_exp[3] = E100;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bif.bin_data = {16'd300, 16'd200, 16'd100};
    bif.req = 3'b111;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bif.busy !== 1'b1 || bif.grant_id !== g_exp[j]) begin
        errors++;
        $display("FAIL rr_grant_%0d: busy=%b gid=%0d, want 1 %0d",
                 j, bif.busy, bif.grant_id, g_exp[j]);
      end
      repeat (16) @(negedge clk);
      a_exp = 3'b001 << g_exp[j];
      checks++;
      if (bif.bcd_valid !== 1'b1 || bif.ack !== a_exp || bif.bcd_out !== b_exp[j]) begin
        errors++;
        $display("FAIL rr_done_%0d: valid=%b ack=%b bcd=%h, want 1 %b %h",
                 j, bif.bcd_valid, bif.ack, bif.bcd_out, a_exp, b_exp[j]);
      end
      if (j == 3) bif.req = '0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    bif.bin_data[15:0] = 16'd5555;
    bif.req = 3'b001;
    @(negedge clk);
    bif.req = '0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;  // during 8th SHIFT cycle
    @(negedge clk);
    checks++;
    if (bif.busy !== 1'b0 || bif.bcd_valid !== 1'b0 || bif.ack !== 3'b000 ||
        bif.bcd_out !== 20'h0 || bif.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b ack=%b bcd=%h gid=%0d, want all 0",
               bif.busy, bif.bcd_valid, bif.ack, bif.bcd_out, bif.grant_id);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.bcd_valid !== 1'b0 || bif.ack !== 3'b000) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_nopulse: %0d pulse cycles seen, want 0", seen);
    end
    bif.bin_data[47:32] = 16'd4321;
    bif.req = 3'b100;
    @(negedge clk);
    repeat (15) @(negedge clk);
    bif.req = '0;
    @(negedge clk);
    checks++;
    if (bif.bcd_valid !== 1'b1 || bif.ack !== 3'b100 || bif.bcd_out !== E4321 ||
        bif.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_next: valid=%b ack=%b bcd=%h gid=%0d, want 1 100 %h 2",
               bif.bcd_valid, bif.ack, bif.bcd_out, bif.grant_id, E4321);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_req;
    bif.bin_data[31:16] = 16'd907;
    bif.req = 3'b010;
    @(negedge clk);
    bif.req = '0;
    bif.bin_data[31:16] = 16'd1;
    repeat (16) @(negedge clk);
    checks++;
    if (bif.bcd_valid !== 1'b1 || bif.ack !== 3'b010 || bif.bcd_out !== E907) begin
      errors++;
      $display("FAIL drop_req: valid=%b ack=%b bcd=%h, want 1 010 %h",
               bif.bcd_valid, bif.ack, bif.bcd_out, E907);
    end
    @(negedge clk);
  endtask

  initial begin
    bif.req = '0;
    bif.bin_data = '0;
    test_reset();
    test_idle();
    test_basic();
    test_values();
    test_round_robin();
    test_reset_mid();
    test_drop_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
